// File: rtl/if_id_stage.sv
// IF/ID pipeline register with decode front end: immediate-type decode,
// register-index extraction and load-use hazard detection against EX.
module if_id_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrF,
  input  logic [DATA_WIDTH-1:0] PCF,
  input  logic [DATA_WIDTH-1:0] PCPlus4F,
  input  logic                  FlushD,
  input  logic                  MemReadE,
  input  logic [4:0]            RdE,
  output logic [2:0]            ImmSrcD,
  output logic [DATA_WIDTH-8:0] ImmInputD,
  output logic [4:0]            Rs1D,
  output logic [4:0]            Rs2D,
  output logic [4:0]            RdD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic                  IllegalD,
  output logic                  StallF,
  output logic                  BubbleE,
  output logic [CNT_WIDTH-1:0]  StallCount
);

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pcp4_q, pcp4_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [2:0] imm_src;
  logic       illegal;
  logic       uses_rs1;
  logic       uses_rs2;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       hazard;
  logic       stall;

  assign opcode = instr_q[6:0];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];

  // Opcode decode: immediate format, source-register usage, legality.
  always_comb begin
    imm_src  = IMM_I;
    illegal  = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    unique case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm_src = IMM_I;
      OP_STORE: begin
        imm_src  = IMM_S;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm_src  = IMM_B;
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm_src  = IMM_U;
        uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        imm_src  = IMM_J;
        uses_rs1 = 1'b0;
      end
      OP_REG: begin
        imm_src  = IMM_I;
        uses_rs2 = 1'b1;
      end
      default: illegal = valid_q;
    endcase
  end

  // Load-use hazard: EX load writes a register this decode slot reads.
  always_comb begin
    hazard = valid_q & MemReadE & (RdE != 5'd0) &
             ((uses_rs1 & (RdE == rs1)) | (uses_rs2 & (RdE == rs2)));
    stall  = hazard & ~FlushD;
  end

  // Next-state: flush squashes the slot, stall holds, else load from fetch.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (FlushD) begin
      instr_d = NOP_INSTR;
      pc_d    = '0;
      pcp4_d  = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      if (cnt_q != {CNT_WIDTH{1'b1}}) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else begin
      instr_d = InstrF;
      pc_d    = PCF;
      pcp4_d  = PCPlus4F;
      valid_d = 1'b1;
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ImmSrcD    = imm_src;
  assign IllegalD   = illegal;
  assign ImmInputD  = instr_q[DATA_WIDTH-1:7];
  assign Rs1D       = rs1;
  assign Rs2D       = rs2;
  assign RdD        = instr_q[11:7];
  assign PCD        = pc_q;
  assign PCPlus4D   = pcp4_q;
  assign ValidD     = valid_q;
  assign StallF     = stall;
  assign BubbleE    = hazard | FlushD;
  assign StallCount = cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: decode, hazard, flush, saturation, reset.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        FlushD, MemReadE;
  logic [4:0]  RdE;
  logic [2:0]  ImmSrcD;
  logic [24:0] ImmInputD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [31:0] PCD, PCPlus4D;
  logic        ValidD, IllegalD, StallF, BubbleE;
  logic [15:0] StallCount;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_SW    = 32'h0072_A023;
  localparam logic [31:0] I_BEQ   = 32'h0020_8463;
  localparam logic [31:0] I_LUI   = 32'h1234_52B7;
  localparam logic [31:0] I_AUIPC = 32'h0000_0097;
  localparam logic [31:0] I_JAL   = 32'h0000_00EF;
  localparam logic [31:0] I_ADD   = 32'h0072_8333;
  localparam logic [31:0] I_BAD   = 32'h0000_007F;
  localparam logic [31:0] I_LUI5  = 32'h0002_82B7;
  localparam logic [31:0] I_NOP   = 32'h0000_0013;

  always #5 clk = ~clk;

  if_id_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .FlushD(FlushD), .MemReadE(MemReadE), .RdE(RdE), .ImmSrcD(ImmSrcD),
    .ImmInputD(ImmInputD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .IllegalD(IllegalD), .StallF(StallF),
    .BubbleE(BubbleE), .StallCount(StallCount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
    InstrF   = ins;
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
  endtask

  task automatic test_reset();
    rst = 1'b1; FlushD = 1'b0; MemReadE = 1'b0; RdE = 5'd0;
    fetch(I_ADDI, 32'h100);
    step(); step();
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ValidD); end
    checks++; if (ImmSrcD !== 3'b000) begin errors++; $display("FAIL reset_immsrc got=%b exp=000", ImmSrcD); end
    checks++; if ({StallF, BubbleE, IllegalD} !== 3'b000) begin errors++; $display("FAIL reset_ctl got=%b exp=000", {StallF, BubbleE, IllegalD}); end
    checks++; if (StallCount !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", StallCount); end
    checks++; if (PCD !== 32'd0 || PCPlus4D !== 32'd0 || ImmInputD !== 25'd0 || RdD !== 5'd0) begin
      errors++; $display("FAIL reset_regs got pc=%h pc4=%h imm=%h rd=%0d exp 0", PCD, PCPlus4D, ImmInputD, RdD); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b0;
    step();
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL ff_valid got=%b exp=1", ValidD); end
    checks++; if (ImmSrcD !== 3'b000 || IllegalD !== 1'b0) begin errors++; $display("FAIL ff_imm got=%b ill=%b exp=000/0", ImmSrcD, IllegalD); end
    checks++; if (ImmInputD !== 25'h00A001) begin errors++; $display("FAIL ff_imminput got=%h exp=00a001", ImmInputD); end
    checks++; if (Rs1D !== 5'd0 || RdD !== 5'd1) begin errors++; $display("FAIL ff_regidx got rs1=%0d rd=%0d exp 0/1", Rs1D, RdD); end
    checks++; if (PCD !== 32'h100 || PCPlus4D !== 32'h104) begin errors++; $display("FAIL ff_pc got=%h/%h exp=100/104", PCD, PCPlus4D); end
  endtask

  task automatic test_opcode_sweep();
    logic [31:0] ins [7];
    logic [2:0]  exp_src [7];
    logic        exp_ill [7];
    ins = '{I_SW, I_BEQ, I_LUI, I_AUIPC, I_JAL, I_ADD, I_BAD};
    exp_src = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b100, 3'b000, 3'b000};
    exp_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      fetch(ins[i], 32'h200 + 32'(i * 4));
      step();
      checks++; if (ImmSrcD !== exp_src[i]) begin errors++; $display("FAIL sweep_immsrc[%0d] got=%b exp=%b", i, ImmSrcD, exp_src[i]); end
      checks++; if (IllegalD !== exp_ill[i]) begin errors++; $display("FAIL sweep_illegal[%0d] got=%b exp=%b", i, IllegalD, exp_ill[i]); end
    end
  endtask

  task automatic test_load_use();
    fetch(I_ADD, 32'h300);
    step();
    MemReadE = 1'b1; RdE = 5'd5;
    fetch(I_NOP, 32'h304);
    #1;
    checks++; if (StallF !== 1'b1 || BubbleE !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b%b exp=11", StallF, BubbleE); end
    checks++; if (StallCount !== 16'd0) begin errors++; $display("FAIL lu_cnt_before got=%h exp=0", StallCount); end
    step();
    checks++; if (PCD !== 32'h300 || Rs1D !== 5'd5 || Rs2D !== 5'd7 || RdD !== 5'd6) begin
      errors++; $display("FAIL lu_hold got pc=%h rs1=%0d rs2=%0d rd=%0d exp 300/5/7/6", PCD, Rs1D, Rs2D, RdD); end
    checks++; if (StallCount !== 16'd1) begin errors++; $display("FAIL lu_cnt_after got=%h exp=1", StallCount); end
    MemReadE = 1'b0;
    #1;
    checks++; if (StallF !== 1'b0 || BubbleE !== 1'b0) begin errors++; $display("FAIL lu_release got=%b%b exp=00", StallF, BubbleE); end
    step();
    checks++; if (PCD !== 32'h304 || RdD !== 5'd0) begin errors++; $display("FAIL lu_advance got pc=%h rd=%0d exp 304/0", PCD, RdD); end
  endtask

  task automatic test_no_false_stall();
    fetch(I_ADD, 32'h400);
    step();
    MemReadE = 1'b1; RdE = 5'd0;
    #1;
    checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL nfs_rd0 got=%b exp=0", StallF); end
    fetch(I_LUI5, 32'h404);
    step();
    RdE = 5'd5;
    #1;
    checks++; if (Rs1D !== 5'd5) begin errors++; $display("FAIL nfs_lui_rs1 got=%0d exp=5", Rs1D); end
    checks++; if (StallF !== 1'b0 || BubbleE !== 1'b0) begin errors++; $display("FAIL nfs_lui got=%b%b exp=00", StallF, BubbleE); end
    MemReadE = 1'b0;
  endtask

  task automatic test_flush();
    fetch(I_ADD, 32'h500);
    step();
    MemReadE = 1'b1; RdE = 5'd7; FlushD = 1'b1;
    #1;
    checks++; if (StallF !== 1'b0 || BubbleE !== 1'b1) begin errors++; $display("FAIL fl_ctl got=%b%b exp=01", StallF, BubbleE); end
    step();
    FlushD = 1'b0; MemReadE = 1'b0;
    checks++; if (ValidD !== 1'b0 || PCD !== 32'd0 || ImmInputD !== 25'd0 || RdD !== 5'd0 || Rs1D !== 5'd0) begin
      errors++; $display("FAIL fl_squash got v=%b pc=%h imm=%h rd=%0d exp 0/0/0/0", ValidD, PCD, ImmInputD, RdD); end
    checks++; if (StallCount !== 16'd1) begin errors++; $display("FAIL fl_cnt got=%h exp=1", StallCount); end
  endtask

  task automatic test_saturate_and_reset();
    fetch(I_ADD, 32'h600);
    step();
    MemReadE = 1'b1; RdE = 5'd5;
    repeat (65539) @(posedge clk);
    #1;
    checks++; if (StallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got=%h exp=ffff", StallCount); end
    step(); step();
    checks++; if (StallCount !== 16'hFFFF || StallF !== 1'b1) begin errors++; $display("FAIL sat_hold got=%h stall=%b exp=ffff/1", StallCount, StallF); end
    checks++; if (PCD !== 32'h600) begin errors++; $display("FAIL sat_pc got=%h exp=600", PCD); end
    rst = 1'b1;
    step();
    checks++; if (StallCount !== 16'd0 || ValidD !== 1'b0 || StallF !== 1'b0) begin
      errors++; $display("FAIL rst_mid got cnt=%h v=%b stall=%b exp 0/0/0", StallCount, ValidD, StallF); end
    rst = 1'b0; MemReadE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_opcode_sweep();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_saturate_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch-to-decode pipeline register of the 5-stage core, combined with the decode-side front end.
- Captures the fetched instruction and PC, then decodes the opcode into ImmSrcD.
- Presents instr[31:7] to the downstream immediate sign-extender, plus the register indices.
- Detects load-use hazards against the EX stage and drives the fetch stall and the EX bubble.

Parameters:
- DATA_WIDTH, 32, instruction/PC width.
- CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- InstrF  input  DATA_WIDTH  instruction from fetch.
- PCF  input  DATA_WIDTH  PC of InstrF.
- PCPlus4F  input  DATA_WIDTH  PCF+4.
- FlushD  input  1  branch/jump redirect: squash the decode slot.
- MemReadE  input  1  instruction in EX is a load.
- RdE  input  5  destination register of the EX instruction.
- ImmSrcD  output  3  immediate type for the sign-extender (encoding below).
- ImmInputD  output  DATA_WIDTH-7  instr[31:7] of the registered instruction.
- Rs1D, Rs2D, RdD  output  5 each  instr[19:15], [24:20], [11:7].
- PCD, PCPlus4D  output  DATA_WIDTH  registered PC values.
- ValidD  output  1  decode slot holds a real instruction.
- IllegalD  output  1  valid instruction with unsupported opcode.
- StallF  output  1  hold PC and the fetch stage.
- BubbleE  output  1  load a NOP into ID/EX next edge.
- StallCount  output  CNT_WIDTH  number of load-use stall cycles.

Behaviour:
- Reset:
  - InstrD register = 32'h00000013 (NOP); PCD = PCPlus4D = 0; ValidD = 0; StallCount = 0.
  - All outputs derive from the reset state: ImmSrcD = 000, IllegalD = 0, StallF = 0, BubbleE = 0.
  - Reset has priority over everything, including mid-stall.
- Register update per rising edge, priority order:
  - rst.
  - FlushD: load NOP, PC = 0, ValidD = 0.
  - Stall: hold all registers.
  - Otherwise load InstrF, PCF, PCPlus4F, and set ValidD = 1.
- Latency: one cycle from F inputs to D outputs.
- Decode (combinational from the registered opcode instr[6:0]) to ImmSrcD:
  - 0010011, 0000011, 1100111 → 000 (I).
  - 0100011 → 001 (S).
  - 1100011 → 010 (B).
  - 0110111, 0010111 → 011 (U).
  - 1101111 → 100 (J).
  - 0110011 → 000 (R, immediate unused).
  - Any other opcode → 000, with IllegalD = ValidD.
- Register-use flags:
  - usesRs1 = 1 for all opcodes except U and J.
  - usesRs2 = 1 for R, S and B only.
- Hazard (combinational):
  - hazard = ValidD & MemReadE & (RdE != 0) & ((usesRs1 & RdE == Rs1D) | (usesRs2 & RdE == Rs2D)).
  - StallF = hazard & ~FlushD.
  - BubbleE = hazard | FlushD.
- Simultaneous FlushD and hazard: the flush wins. The slot is squashed, StallF = 0, and the counter does not increment.
- A stall lasts exactly as long as the hazard holds. The load advances, so normally one cycle; hold is indefinite while inputs keep the hazard.
- StallCount increments by 1 on each edge where StallF = 1; it saturates at all-ones, no wrap.
- ImmInputD, Rs1D, Rs2D and RdD are driven from the register even when ValidD = 0. Consumers qualify them with ValidD.

Test Plan:
- Reset then release, with InstrF = 0x00500093 (addi x1,x0,5), PCF = 0x100 → one cycle later:
  - ValidD = 1, ImmSrcD = 000, ImmInputD = 0x00A001, Rs1D = 0, RdD = 1, PCD = 0x100, PCPlus4D = 0x104.
- Opcode sweep with one instruction each (sw, beq, lui, auipc, jal, add, 0x0000007F) → ImmSrcD values:
  - sw → 001, beq → 010, lui → 011, auipc → 011, jal → 100, add → 000.
  - 0x0000007F → 000 with IllegalD = 1; IllegalD = 0 for all the others.
- Load-use: decode holds add x6,x5,x7 while MemReadE = 1, RdE = 5:
  - StallF = 1 and BubbleE = 1; registers hold for one edge; StallCount goes 0 → 1.
  - Next cycle MemReadE = 0: StallF = 0 and the new InstrF loads.
- No false stall:
  - RdE = 0 with MemReadE = 1 → StallF = 0.
  - lui x5 in decode with RdE = 5 → StallF = 0 (usesRs1 = 0).
- FlushD = 1 while the hazard is true → StallF = 0, BubbleE = 1; next edge ValidD = 0, instruction = NOP, StallCount unchanged.
- Force 2^CNT_WIDTH+3 consecutive stall cycles → StallCount = 0xFFFF and stays there. Then assert rst mid-stall → StallCount = 0, ValidD = 0, StallF = 0.
